retire_monitor: RTL
===================

RETIRE_MONITOR -- requirements
Module: retire_monitor

Interface
REQ-001 Parameter XLEN, default 32, width of retired PC and stop addresses, SHALL be supported.
REQ-002 Parameter NUM_STOP, default 4, number of independent stop-address slots (1..16), SHALL be supported.
REQ-003 Parameter CNT_W, default 32, width of cycle/retire counters and timeout limit, SHALL be supported.
REQ-004 Parameter STALL_LIMIT, default 1024, consecutive non-retiring RUN cycles that trigger a stall halt (0 = disabled), SHALL be supported.
REQ-005 Ports SHALL be, in order:
 clk  in  1  single clock, rising edge
 rstn  in  1  synchronous, active-high reset
 start  in  1  arm monitor (IDLE only)
 clear  in  1  return HALTED to IDLE
 wb_valid  in  1  instruction retires in WB this cycle
 pc_wb  in  XLEN  PC of retiring instruction
 stop_en  in  NUM_STOP  per-slot enable
 stop_addr  in  NUM_STOP*XLEN  slot i at bits [i*XLEN +: XLEN]
 timeout_limit  in  CNT_W  max RUN cycles, 0 = disabled
 running  out  1  state == RUN
 halted  out  1  state == HALTED
 halt_pulse  out  1  one-cycle pulse on HALTED entry
 halt_cause  out  2  0 NONE, 1 ADDR, 2 TIMEOUT, 3 STALL
 halt_idx  out  4  matching slot index (ADDR only, else 0)
 halt_pc  out  XLEN  pc_wb captured at halt (0 if not ADDR)
 cycle_cnt  out  CNT_W  RUN cycles elapsed
 retire_cnt  out  CNT_W  instructions retired in RUN

Function
REQ-006 FSM states IDLE, RUN, HALTED SHALL exist; rstn forces IDLE.
REQ-007 IDLE->RUN on start; on that edge cycle_cnt, retire_cnt, stall counter, halt_cause, halt_idx, halt_pc SHALL clear to 0.
REQ-008 In RUN, cycle_cnt SHALL increment by 1 every cycle, saturating at all-ones.
REQ-009 In RUN, retire_cnt SHALL increment on wb_valid, saturating at all-ones; the halting retirement itself is counted.
REQ-010 Address hit SHALL be wb_valid & stop_en[i] & (pc_wb == slot i); lowest matching index wins.
REQ-011 Timeout hit SHALL be timeout_limit != 0 and cycle_cnt + 1 == timeout_limit (halt after exactly timeout_limit RUN cycles).
REQ-012 Stall counter SHALL reset on wb_valid, else increment; stall hit when STALL_LIMIT != 0 and it reaches STALL_LIMIT-1 on a non-retiring cycle.
REQ-013 Same-cycle hits SHALL resolve ADDR > TIMEOUT > STALL.
REQ-014 Any hit in RUN SHALL move to HALTED on the next edge with halt_cause/halt_idx/halt_pc registered; latency one cycle from the hitting retirement to halted=1.
REQ-015 halt_pulse SHALL be high only in the first HALTED cycle.
REQ-016 In HALTED, counters and capture registers SHALL freeze; wb_valid and start SHALL be ignored.
REQ-017 HALTED->IDLE on clear; clear SHALL be ignored in IDLE and RUN; in IDLE, registers keep last values until next start.
REQ-018 start and clear asserted together in HALTED SHALL act as clear only.
REQ-019 stop_en/stop_addr/timeout_limit changes SHALL take effect on the same cycle (combinational compare, no shadowing).

Reset
REQ-020 rstn high at any clock edge, including mid-RUN or mid-halt, SHALL force IDLE and all outputs and counters to 0 on that edge.
REQ-021 rstn SHALL have priority over start, clear and all hits.

Structure
REQ-022 Package retire_monitor_pkg SHALL hold the state encoding and halt_cause constants (CAUSE_NONE/ADDR/TIMEOUT/STALL).
REQ-023 Sub-module retire_match SHALL implement the NUM_STOP comparator array and lowest-index priority encoder (hit, idx outputs), purely combinational.
REQ-024 Counters and FSM SHALL reside in retire_monitor; no latches, single always-block clock domain.

Verification
REQ-025 Slot0=0x80000078 enabled, start, retire 30 instrs ending at 0x80000078 -> halted next cycle, cause 1, idx 0, halt_pc 0x80000078, retire_cnt 30, halt_pulse 1 cycle.
REQ-026 Slots1 and 3 both =0x80000010 enabled -> hit reports idx 1; slot with stop_en=0 never matches.
REQ-027 timeout_limit=100, no address match, STALL_LIMIT disabled -> halted after cycle_cnt=100, cause 2.
REQ-028 STALL_LIMIT=8, wb_valid low after start -> halt after 8 RUN cycles, cause 3; a single wb_valid at cycle 5 restarts the count.
REQ-029 Address hit on the cycle timeout also fires -> cause 1; then clear+start same cycle -> IDLE, next start re-arms with counters 0.
REQ-030 rstn pulsed mid-RUN at cycle_cnt=50 -> next cycle IDLE, all outputs 0; CNT_W=4 run of 20 cycles, timeout 0 -> cycle_cnt saturates at 15.

Source files
------------

// File: rtl/retire_monitor_pkg.sv
// Shared encodings for the retirement monitor: FSM states and halt causes.
package retire_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ADDR    = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0] CAUSE_STALL   = 2'd3;

  localparam int IDX_W = 4;

  // Encodes the winning cause for a cycle; address beats timeout beats stall.
  function automatic logic [1:0] pick_cause(input logic addr_hit,
                                            input logic timeout_hit,
                                            input logic stall_hit);
    logic [1:0] cause;
    cause = CAUSE_NONE;
    if (addr_hit) begin
      cause = CAUSE_ADDR;
    end else if (timeout_hit) begin
      cause = CAUSE_TIMEOUT;
    end else if (stall_hit) begin
      cause = CAUSE_STALL;
    end
    return cause;
  endfunction

endpackage

// File: rtl/retire_match.sv
// Stop-address comparator array with a lowest-index-wins priority encoder.
module retire_match
  import retire_monitor_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_STOP = 4
) (
  input  logic                     valid,
  input  logic [XLEN-1:0]          pc,
  input  logic [NUM_STOP-1:0]      stop_en,
  input  logic [NUM_STOP*XLEN-1:0] stop_addr,
  output logic                     hit,
  output logic [IDX_W-1:0]         idx
);

  logic [NUM_STOP-1:0] slot_hit;

  always_comb begin
    slot_hit = '0;
    for (int i = 0; i < NUM_STOP; i++) begin
      slot_hit[i] = valid && stop_en[i] && (pc == stop_addr[i*XLEN +: XLEN]);
    end
  end

  // Walk from the top slot down so the lowest matching index is the last write.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_STOP - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/retire_monitor.sv
// Run-control monitor: arms on start, counts RUN cycles and retirements,
// halts on stop address, timeout or retirement stall, and holds the capture.
module retire_monitor
  import retire_monitor_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NUM_STOP    = 4,
  parameter int CNT_W       = 32,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic                     clear,
  input  logic                     wb_valid,
  input  logic [XLEN-1:0]          pc_wb,
  input  logic [NUM_STOP-1:0]      stop_en,
  input  logic [NUM_STOP*XLEN-1:0] stop_addr,
  input  logic [CNT_W-1:0]         timeout_limit,
  output logic                     running,
  output logic                     halted,
  output logic                     halt_pulse,
  output logic [1:0]               halt_cause,
  output logic [3:0]               halt_idx,
  output logic [XLEN-1:0]          halt_pc,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [CNT_W-1:0]         retire_cnt
);

  localparam logic [CNT_W-1:0] STALL_LAST =
    CNT_W'((STALL_LIMIT > 0) ? (STALL_LIMIT - 1) : 0);

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] cycle_inc;
  logic [CNT_W-1:0] cycle_next;
  logic [CNT_W-1:0] retire_next;
  logic [CNT_W-1:0] stall_next;

  logic             addr_hit;
  logic [IDX_W-1:0] addr_idx;
  logic             timeout_hit;
  logic             stall_hit;
  logic             any_hit;
  logic             in_run;

  retire_match #(
    .XLEN     (XLEN),
    .NUM_STOP (NUM_STOP)
  ) u_match (
    .valid     (wb_valid),
    .pc        (pc_wb),
    .stop_en   (stop_en),
    .stop_addr (stop_addr),
    .hit       (addr_hit),
    .idx       (addr_idx)
  );

  assign in_run = (state == ST_RUN);

  // Saturating increments; cycle_inc wraps at all-ones, which can never equal
  // a nonzero limit that the counter has not already passed.
  always_comb begin
    cycle_inc   = cycle_cnt + CNT_W'(1);
    cycle_next  = (&cycle_cnt) ? cycle_cnt : cycle_inc;
    retire_next = retire_cnt;
    if (wb_valid && !(&retire_cnt)) begin
      retire_next = retire_cnt + CNT_W'(1);
    end
    stall_next = '0;
    if (!wb_valid) begin
      stall_next = (&stall_cnt) ? stall_cnt : stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    timeout_hit = 1'b0;
    stall_hit   = 1'b0;
    if (in_run) begin
      timeout_hit = (timeout_limit != '0) && (cycle_inc == timeout_limit);
      stall_hit   = (STALL_LIMIT != 0) && !wb_valid && (stall_cnt == STALL_LAST);
    end
    any_hit = in_run && (addr_hit || timeout_hit || stall_hit);
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (any_hit) begin
          state_next = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (clear) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Counters and captures only move in IDLE (on start) and RUN; HALTED freezes.
  always_ff @(posedge clk) begin
    if (rstn) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      stall_cnt  <= '0;
      halt_cause <= CAUSE_NONE;
      halt_idx   <= '0;
      halt_pc    <= '0;
      halt_pulse <= 1'b0;
    end else begin
      halt_pulse <= any_hit;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            stall_cnt  <= '0;
            halt_cause <= CAUSE_NONE;
            halt_idx   <= '0;
            halt_pc    <= '0;
          end
        end
        ST_RUN: begin
          cycle_cnt  <= cycle_next;
          retire_cnt <= retire_next;
          stall_cnt  <= stall_next;
          if (any_hit) begin
            halt_cause <= pick_cause(addr_hit, timeout_hit, stall_hit);
            halt_idx   <= addr_hit ? addr_idx : '0;
            halt_pc    <= addr_hit ? pc_wb : '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign running = (state == ST_RUN);
  assign halted  = (state == ST_HALTED);

endmodule
